// File: rtl/intan_headstage_emulator.sv
// intan_headstage_emulator
//   SPI peripheral that stands in for an Intan dual-die headstage on the
//   controller's CSn/SCLK/COPI link. Each CSn-low frame carries one 16-bit
//   command. The response is a 32-bit DDR word on CIPO, returned two frames
//   later (two-slot pipeline).
//
// Ports
//   clk        in   system clock (controller domain)
//   rstn       in   synchronous active-low reset
//   enable     in   0: ignore frames, hold cipo low
//   csn        in   chip select, active low
//   sclk       in   serial clock
//   copi       in   command data, MSB first, sampled on sclk rise
//   cipo       out  DDR response (A bits on even half-cycles, B bits on odd)
//   frames_rx  out  count of valid 16-bit frames decoded
//   last_cmd   out  last valid command word
//   bad_frame  out  sticky: a frame ended with a bit count other than 16
//
// state  | meaning
// IDLE   | waiting for csn fall
// SHIFT  | frame active: shift copi in, step the cipo bit index on sclk edges
// DECODE | one cycle: execute the command or flag a bad frame
module intan_headstage_emulator #(
  parameter int         SYNC_STAGES = 2,
  parameter int         CIPO_DELAY  = 0,
  parameter logic [7:0] CHIP_ID     = 8'd1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        csn,
  input  logic        sclk,
  input  logic        copi,
  output logic        cipo,
  output logic [31:0] frames_rx,
  output logic [15:0] last_cmd,
  output logic        bad_frame
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE} state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, copi_sync_q;
  logic                   csn_prev_q, sclk_prev_q;
  logic                   csn_s, sclk_s, copi_s;
  logic                   csn_fall, csn_rise, sclk_rise, sclk_fall;

  // csn resets high so a released reset never looks like a frame start
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      csn_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      csn_prev_q  <= csn_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign csn_fall  = csn_prev_q & ~csn_s;
  assign csn_rise  = ~csn_prev_q & csn_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  state_t state_q, state_d;
  logic   load_tx, shift_en, do_decode;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (csn_fall) state_d = ST_SHIFT;
      ST_SHIFT:  if (csn_rise) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  // shift_en excludes the cycle where csn rises, so a coincident sclk
  // edge is dropped
  always_comb begin
    load_tx   = (state_q == ST_IDLE)  && (state_d == ST_SHIFT);
    shift_en  = (state_q == ST_SHIFT) && (state_d == ST_SHIFT);
    do_decode = (state_q == ST_DECODE) && enable;
  end

  // ---------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------
  logic [31:0] tx_q, tx_d;
  logic [4:0]  k_q, k_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        bit_q, bit_d;
  logic [31:0] pipe0_q, pipe1_q;

  always_comb begin
    tx_d     = tx_q;
    k_d      = k_q;
    rx_d     = rx_q;
    bitcnt_d = bitcnt_q;
    if (load_tx) begin
      tx_d     = pipe1_q;
      k_d      = 5'd31;
      rx_d     = '0;
      bitcnt_d = '0;
    end else if (shift_en) begin
      if (sclk_rise) begin
        rx_d     = {rx_q[14:0], copi_s};
        bitcnt_d = (bitcnt_q == 5'd31) ? bitcnt_q : bitcnt_q + 5'd1;
      end
      if (sclk_rise || sclk_fall)
        k_d = (k_q == 5'd0) ? k_q : k_q - 5'd1;
    end
    // Registering the bit selected by the next-state index keeps the pin
    // to cipo latency at SYNC_STAGES + 1 (+ CIPO_DELAY).
    bit_d = (state_d == ST_SHIFT) ? tx_d[k_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_q     <= '0;
      k_q      <= 5'd31;
      rx_q     <= '0;
      bitcnt_q <= '0;
      bit_q    <= 1'b0;
    end else begin
      tx_q     <= tx_d;
      k_q      <= k_d;
      rx_q     <= rx_d;
      bitcnt_q <= bitcnt_d;
      bit_q    <= bit_d;
    end
  end

  // ---------------------------------------------------------------------
  // Command execute
  // ---------------------------------------------------------------------
  logic [7:0]  regfile_q [22];
  logic [31:0] frames_q;
  logic [15:0] last_q;
  logic        bad_q;
  logic [5:0]  cmd_r;
  logic [7:0]  cmd_dat, rd_v;
  logic [15:0] a_v, b_v;
  logic        wr_en;
  logic [31:0] resp_w;

  always_comb begin
    cmd_r   = rx_q[13:8];
    cmd_dat = rx_q[7:0];
    a_v     = '0;
    b_v     = '0;
    wr_en   = 1'b0;
    rd_v    = '0;
    resp_w  = '0;
    case (rx_q[15:14])
      2'b00: begin
        if (cmd_r < 6'd32) begin
          a_v = {cmd_r, frames_q[9:0]};
          b_v = ~a_v;
        end
      end
      2'b01: begin
        a_v = '0;
        b_v = '0;
      end
      2'b10: begin
        wr_en = (cmd_r < 6'd22);
        a_v   = {8'hFF, cmd_dat};
        b_v   = a_v;
      end
      default: begin
        if (cmd_r < 6'd22) rd_v = regfile_q[cmd_r[4:0]];
        else begin
          case (cmd_r)
            6'd40:   rd_v = 8'h49;
            6'd41:   rd_v = 8'h4E;
            6'd42:   rd_v = 8'h54;
            6'd43:   rd_v = 8'h41;
            6'd44:   rd_v = 8'h4E;
            6'd60:   rd_v = 8'h01;
            6'd63:   rd_v = CHIP_ID;
            default: rd_v = 8'h00;
          endcase
        end
        a_v = {8'h00, rd_v};
        b_v = a_v;
      end
    endcase
    // DDR interleave: A on odd word bits, B on even, both MSB first
    for (int j = 0; j < 16; j++) begin
      resp_w[31-2*j] = a_v[15-j];
      resp_w[30-2*j] = b_v[15-j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe0_q  <= '0;
      pipe1_q  <= '0;
      frames_q <= '0;
      last_q   <= '0;
      bad_q    <= 1'b0;
      for (int i = 0; i < 22; i++) regfile_q[i] <= '0;
    end else if (do_decode) begin
      if (bitcnt_q == 5'd16) begin
        pipe1_q  <= pipe0_q;
        pipe0_q  <= resp_w;
        last_q   <= rx_q;
        frames_q <= frames_q + 32'd1;
        if (wr_en) regfile_q[cmd_r[4:0]] <= cmd_dat;
      end else begin
        bad_q <= 1'b1;
      end
    end
  end

  assign frames_rx = frames_q;
  assign last_cmd  = last_q;
  assign bad_frame = bad_q;

  // ---------------------------------------------------------------------
  // Cable-length emulation on cipo
  // ---------------------------------------------------------------------
  generate
    if (CIPO_DELAY == 0) begin : g_nodly
      assign cipo = bit_q;
    end else begin : g_dly
      logic [CIPO_DELAY-1:0] dly_q;
      always_ff @(posedge clk) begin
        if (!rstn) dly_q <= '0;
        else begin
          dly_q[0] <= bit_q;
          for (int i = 1; i < CIPO_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign cipo = dly_q[CIPO_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_intan_headstage_emulator.sv
module tb_intan_headstage_emulator;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0, enable = 1'b1, csn = 1'b1, sclk = 1'b0, copi = 1'b0;
  logic        cipo0, cipo3, bad0, bad3;
  logic [31:0] fr0, fr3;
  logic [15:0] lc0, lc3;

  always #5 clk = ~clk;

  intan_headstage_emulator dut (
    .clk(clk), .rstn(rstn), .enable(enable), .csn(csn), .sclk(sclk), .copi(copi),
    .cipo(cipo0), .frames_rx(fr0), .last_cmd(lc0), .bad_frame(bad0));

  intan_headstage_emulator #(.CIPO_DELAY(3)) dut_d3 (
    .clk(clk), .rstn(rstn), .enable(enable), .csn(csn), .sclk(sclk), .copi(copi),
    .cipo(cipo3), .frames_rx(fr3), .last_cmd(lc3), .bad_frame(bad3));

  int checks = 0, failures = 0;

  // reference model state
  logic [7:0]  m_reg [22];
  int unsigned m_frames;
  logic [31:0] m_pipe0, m_pipe1;
  logic [15:0] m_last;
  bit          m_bad;
  logic [31:0] got0, got3;

  bit   t5_done;
  logic h0[$], h3[$];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_a(input logic [31:0] w);
    logic [15:0] a;
    for (int j = 0; j < 16; j++) a[15-j] = w[31-2*j];
    return a;
  endfunction

  function automatic logic [15:0] word_b(input logic [31:0] w);
    logic [15:0] b;
    for (int j = 0; j < 16; j++) b[15-j] = w[30-2*j];
    return b;
  endfunction

  function automatic logic [31:0] make_word(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] w;
    for (int j = 0; j < 16; j++) begin
      w[31-2*j] = a[15-j];
      w[30-2*j] = b[15-j];
    end
    return w;
  endfunction

  function automatic logic [7:0] m_read(input int r);
    string s;
    s = "INTAN";
    if (r < 22) return m_reg[r];
    if (r >= 40 && r <= 44) return s[r-40];
    if (r == 60) return 8'h01;
    if (r == 63) return 8'd1;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 22; i++) m_reg[i] = 8'h00;
    m_frames = 0; m_pipe0 = '0; m_pipe1 = '0; m_last = '0; m_bad = 0;
  endtask

  task automatic model_frame(input logic [15:0] cmd, input int np);
    logic [15:0] a, b;
    int r;
    if (np != 16) begin
      m_bad = 1;
      return;
    end
    r = int'(cmd[13:8]);
    a = 16'h0; b = 16'h0;
    case (cmd[15:14])
      2'b00: if (r < 32) begin
        a = 16'((r * 1024) + (m_frames % 1024));
        b = ~a;
      end
      2'b01: ;
      2'b10: begin
        a = {8'hFF, cmd[7:0]}; b = a;
        if (r < 22) m_reg[r] = cmd[7:0];
      end
      default: begin
        a = {8'h00, m_read(r)}; b = a;
      end
    endcase
    m_pipe1 = m_pipe0;
    m_pipe0 = make_word(a, b);
    m_frames++;
    m_last = cmd;
  endtask

  task automatic do_reset();
    rstn = 0; csn = 1; sclk = 0; copi = 0; enable = 1;
    wait_clk(6);
    rstn = 1;
    wait_clk(4);
    model_reset();
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int np);
    got0 = '0; got3 = '0;
    csn = 0;
    for (int p = 0; p < np; p++) begin
      copi = (p < 16) ? cmd[15-p] : 1'b0;
      wait_clk(HALF);
      if (p < 16) begin got0[31-2*p] = cipo0; got3[31-2*p] = cipo3; end
      sclk = 1;
      wait_clk(HALF);
      if (p < 16) begin got0[30-2*p] = cipo0; got3[30-2*p] = cipo3; end
      sclk = 0;
    end
    wait_clk(HALF);
    csn = 1; copi = 0;
    wait_clk(10);
  endtask

  task automatic frame_and_check(input logic [15:0] cmd, input int np);
    logic [31:0] exp_w;
    exp_w = m_pipe1;
    run_frame(cmd, np);
    model_frame(cmd, np);
    checks++;
    if (np == 16 && got0 !== exp_w) begin
      failures++;
      $display("FAIL frame_word cmd=%h got=%h exp=%h", cmd, got0, exp_w);
    end
    checks++;
    if (np == 16 && got3 !== exp_w) begin
      failures++;
      $display("FAIL frame_word_d3 cmd=%h got=%h exp=%h", cmd, got3, exp_w);
    end
    checks++;
    if (fr0 !== m_frames || lc0 !== m_last || bad0 !== m_bad) begin
      failures++;
      $display("FAIL frame_status cmd=%h frames=%0d/%0d last=%h/%h bad=%b/%b",
               cmd, fr0, m_frames, lc0, m_last, bad0, m_bad);
    end
    checks++;
    if (cipo0 !== 1'b0 || cipo3 !== 1'b0) begin
      failures++;
      $display("FAIL cipo_idle cmd=%h got=%b/%b exp=0", cmd, cipo0, cipo3);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cipo0 !== 1'b0 || fr0 !== 32'd0 || lc0 !== 16'd0 || bad0 !== 1'b0 ||
        cipo3 !== 1'b0 || fr3 !== 32'd0) begin
      failures++;
      $display("FAIL reset_state cipo=%b frames=%0d last=%h bad=%b exp all 0",
               cipo0, fr0, lc0, bad0);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    frame_and_check(16'h8A5C, 16);
    frame_and_check(16'hCA00, 16);
    frame_and_check(16'hCA00, 16);
    checks++;
    if (word_a(got0) !== 16'hFF5C || word_b(got0) !== 16'hFF5C) begin
      failures++;
      $display("FAIL write_echo got A=%h B=%h exp FF5C", word_a(got0), word_b(got0));
    end
    frame_and_check(16'h4000, 16);
    checks++;
    if (word_a(got0) !== 16'h005C || word_b(got0) !== 16'h005C) begin
      failures++;
      $display("FAIL read_back got A=%h B=%h exp 005C", word_a(got0), word_b(got0));
    end
  endtask

  task automatic test_rom_regs();
    logic [15:0] exp_a [6];
    exp_a = '{16'h0049, 16'h004E, 16'h0054, 16'h0041, 16'h004E, 16'h0001};
    do_reset();
    frame_and_check(16'hE800, 16);
    frame_and_check(16'hE900, 16);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] cmd;
      cmd = (i < 3) ? 16'hEA00 + 16'(i * 256) : 16'h4000;
      if (i == 2) cmd = 16'hFF00;
      if (i == 0) cmd = 16'hEA00;
      if (i == 1) cmd = 16'hEB00;
      if (i == 2) cmd = 16'hEC00;
      if (i == 3) cmd = 16'hFF00;
      frame_and_check(cmd, 16);
      checks++;
      if (word_a(got0) !== exp_a[i]) begin
        failures++;
        $display("FAIL rom_read idx=%0d got=%h exp=%h", i, word_a(got0), exp_a[i]);
      end
    end
  endtask

  task automatic test_convert();
    do_reset();
    for (int i = 0; i < 7; i++) frame_and_check(16'h4000, 16);
    frame_and_check(16'h0500, 16);
    frame_and_check(16'h4000, 16);
    frame_and_check(16'h4000, 16);
    checks++;
    if (word_a(got0) !== 16'h1407 || word_b(got0) !== 16'hEBF8) begin
      failures++;
      $display("FAIL convert got A=%h B=%h exp 1407/EBF8", word_a(got0), word_b(got0));
    end
    frame_and_check(16'h2500, 16);
    frame_and_check(16'h4000, 16);
    frame_and_check(16'h4000, 16);
    checks++;
    if (got0 !== 32'h0) begin
      failures++;
      $display("FAIL convert_hi_ch got=%h exp=0", got0);
    end
  endtask

  task automatic test_bad_frame();
    logic [31:0] pre_w;
    logic [31:0] pre_frames;
    do_reset();
    frame_and_check(16'h8133, 16);
    frame_and_check(16'h82C4, 16);
    pre_w = m_pipe1;
    pre_frames = fr0;
    frame_and_check(16'h8777, 8);
    checks++;
    if (bad0 !== 1'b1 || fr0 !== pre_frames) begin
      failures++;
      $display("FAIL bad_frame bad=%b frames=%0d exp bad=1 frames=%0d", bad0, fr0, pre_frames);
    end
    frame_and_check(16'h4000, 16);
    checks++;
    if (got0 !== pre_w || word_a(got0) !== 16'hFF33) begin
      failures++;
      $display("FAIL bad_no_advance got=%h exp=%h", got0, pre_w);
    end
  endtask

  task automatic test_cipo_delay();
    int mism, ones;
    do_reset();
    frame_and_check(16'h81A5, 16);
    frame_and_check(16'h835A, 16);
    h0.delete(); h3.delete();
    t5_done = 0;
    fork
      begin frame_and_check(16'h4000, 16); t5_done = 1; end
      begin
        while (!t5_done) begin
          @(negedge clk);
          h0.push_back(cipo0);
          h3.push_back(cipo3);
        end
      end
    join
    mism = 0; ones = 0;
    for (int t = 0; t < h0.size(); t++) begin
      if (h0[t] === 1'b1) ones++;
      if (t >= 3 && h3[t] !== h0[t-3]) mism++;
      if (t < 3 && h3[t] !== 1'b0) mism++;
    end
    checks++;
    if (mism != 0 || ones == 0) begin
      failures++;
      $display("FAIL cipo_delay3 mismatches=%0d ones=%0d exp 0 mismatches, ones>0", mism, ones);
    end
  endtask

  task automatic test_enable();
    logic [31:0] pre;
    do_reset();
    frame_and_check(16'h8011, 16);
    frame_and_check(16'h8022, 16);
    pre = fr0;
    enable = 0;
    run_frame(16'h8033, 16);
    checks++;
    if (fr0 !== pre || got0 !== 32'h0 || bad0 !== 1'b0) begin
      failures++;
      $display("FAIL enable_off frames=%0d exp %0d word=%h exp 0", fr0, pre, got0);
    end
    enable = 1;
    wait_clk(4);
    frame_and_check(16'h4000, 16);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    frame_and_check(16'h83AB, 16);
    frame_and_check(16'h84CD, 16);
    csn = 0;
    for (int p = 0; p < 9; p++) begin
      copi = p[0];
      wait_clk(HALF);
      sclk = 1;
      wait_clk(HALF);
      if (p != 8) sclk = 0;
    end
    rstn = 0;
    wait_clk(2);
    checks++;
    if (cipo0 !== 1'b0 || fr0 !== 32'd0 || lc0 !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid cipo=%b frames=%0d last=%h exp 0", cipo0, fr0, lc0);
    end
    csn = 1; sclk = 0; copi = 0;
    wait_clk(6);
    rstn = 1;
    wait_clk(4);
    model_reset();
    frame_and_check(16'hC300, 16);
    frame_and_check(16'h4000, 16);
    frame_and_check(16'h4000, 16);
    checks++;
    if (got0 !== 32'h0 || fr0 !== 32'd3) begin
      failures++;
      $display("FAIL reset_regfile got=%h frames=%0d exp 0/3", got0, fr0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] cmd;
      int np;
      cmd = 16'($urandom);
      np = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : 16;
      frame_and_check(cmd, np);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rom_regs();
    test_convert();
    test_bad_frame();
    test_cipo_delay();
    test_enable();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
